// File: rtl/key_buffer_pkg.sv
// key_buffer_pkg: shared definitions for the calculator keypad front end.
//   - 4-bit key codes produced by the encoder
//   - position of the valid bit inside the 5-bit eBCD word
//   - debounce state encoding
//   - helpers that classify and encode a sampled key vector
package key_buffer_pkg;

  localparam logic [3:0] KEY_0         = 4'h0;
  localparam logic [3:0] KEY_1         = 4'h1;
  localparam logic [3:0] KEY_2         = 4'h2;
  localparam logic [3:0] KEY_3         = 4'h3;
  localparam logic [3:0] KEY_4         = 4'h4;
  localparam logic [3:0] KEY_5         = 4'h5;
  localparam logic [3:0] KEY_6         = 4'h6;
  localparam logic [3:0] KEY_7         = 4'h7;
  localparam logic [3:0] KEY_8         = 4'h8;
  localparam logic [3:0] KEY_9         = 4'h9;
  localparam logic [3:0] KEY_DIVMOD    = 4'hA;
  localparam logic [3:0] KEY_TIMES     = 4'hB;
  localparam logic [3:0] KEY_PLUSMINUS = 4'hC;
  localparam logic [3:0] KEY_AC        = 4'hD;
  localparam logic [3:0] KEY_ANS       = 4'hE;
  localparam logic [3:0] KEY_EQU       = 4'hF;

  localparam int EBCD_VALID_BIT = 4;

  typedef enum logic [1:0] {
    DEB_IDLE,
    DEB_PRESS_WAIT,
    DEB_HELD,
    DEB_RELEASE_WAIT
  } deb_state_t;

  // True when exactly one line is set (clearing the lowest set bit leaves zero).
  function automatic logic is_single(input logic [15:0] k);
    return (k != 16'h0) && ((k & (k - 16'h1)) == 16'h0);
  endfunction

  // Index of the highest set line; only meaningful when is_single(k).
  function automatic logic [3:0] key_encode(input logic [15:0] k);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++)
      if (k[i]) idx = 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// key_fifo: circular buffer of 4-bit key codes.
//   sw_clk, rst   : clock, async active-low reset
//   push, din     : write request and code
//   pop           : read-and-delete request (ignored when empty)
//   dout          : head code, 0 when empty (combinational from storage)
//   full, empty   : status
//   count         : number of stored codes
// A push while full is only taken when a pop frees the slot on the same edge.
module key_fifo #(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          sw_clk,
  input  logic          rst,
  input  logic          push,
  input  logic [3:0]    din,
  input  logic          pop,
  output logic [3:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: it is never visible while count is zero.
  always_ff @(posedge sw_clk) begin
    if (do_push) mem[wptr] <= din;
  end

  assign dout = empty ? 4'h0 : mem[rptr];

endmodule

// File: rtl/key_buffer.sv
// key_buffer: keypad front end of the calculator.
//   sw_clk, rst : clock, async active-low reset
//   keys        : raw active-high key lines, keys[i] = key code i
//   mode        : 1 = consume head this cycle (valid is masked meanwhile)
//   eBCD        : {valid, head code}
//   key_count   : queued codes
//   key_pressed : one-cycle pulse per debounced press (stored or not)
//   overflow    : one-cycle pulse when a press is dropped on a full queue
module key_buffer
  import key_buffer_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DEB_CYCLES = 4,
  localparam int CW        = $clog2(DEB_CYCLES + 1)
) (
  input  logic                     sw_clk,
  input  logic                     rst,
  input  logic [15:0]              keys,
  input  logic                     mode,
  output logic [4:0]               eBCD,
  output logic [$clog2(DEPTH):0]   key_count,
  output logic                     key_pressed,
  output logic                     overflow
);

  localparam bit INSTANT = (DEB_CYCLES == 1);

  logic [15:0]  samp;
  deb_state_t   state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic [3:0]   cand, cand_nx, head;
  logic         single, none, reached, push;
  logic         full, empty;

  assign single  = is_single(samp);
  assign none    = (samp == 16'h0);
  assign cnt_inc = cnt + 1'b1;
  assign reached = (cnt_inc >= CW'(DEB_CYCLES));

  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      samp        <= '0;
      state       <= DEB_IDLE;
      cnt         <= '0;
      cand        <= '0;
      key_pressed <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      samp        <= keys;
      state       <= state_nx;
      cnt         <= cnt_nx;
      cand        <= cand_nx;
      key_pressed <= push;
      // Full implies non-empty, so the pop that would rescue the push is just mode.
      overflow    <= push & full & ~mode;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cand_nx  = cand;
    push     = 1'b0;
    case (state)
      DEB_IDLE: begin
        if (single) begin
          cand_nx = key_encode(samp);
          if (INSTANT) begin
            state_nx = DEB_HELD;
            cnt_nx   = '0;
            push     = 1'b1;
          end else begin
            state_nx = DEB_PRESS_WAIT;
            cnt_nx   = CW'(1);
          end
        end
      end
      DEB_PRESS_WAIT: begin
        if (samp == (16'h1 << cand)) begin
          if (reached) begin
            state_nx = DEB_HELD;
            cnt_nx   = '0;
            push     = 1'b1;
          end else begin
            cnt_nx = cnt_inc;
          end
        end else begin
          state_nx = DEB_IDLE;
          cnt_nx   = '0;
        end
      end
      DEB_HELD: begin
        // Chords and extra keys while held never produce a second push.
        if (none) begin
          state_nx = INSTANT ? DEB_IDLE : DEB_RELEASE_WAIT;
          cnt_nx   = INSTANT ? '0 : CW'(1);
        end
      end
      DEB_RELEASE_WAIT: begin
        if (none) begin
          if (reached) begin
            state_nx = DEB_IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt_inc;
          end
        end else begin
          state_nx = DEB_HELD;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = DEB_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  key_fifo #(.DEPTH(DEPTH)) u_fifo (
    .sw_clk (sw_clk),
    .rst    (rst),
    .push   (push),
    .din    (cand),
    .pop    (mode),
    .dout   (head),
    .full   (full),
    .empty  (empty),
    .count  (key_count)
  );

  // Valid is masked while mode is high so a registered one-cycle mode
  // cannot see the next head before it has been re-presented.
  assign eBCD[EBCD_VALID_BIT] = ~empty & ~mode;
  assign eBCD[3:0]            = head;

endmodule

// File: tb/tb_key_buffer.sv
module tb_key_buffer;
  localparam int DEPTH = 8;
  localparam int DEB   = 4;

  logic        sw_clk = 1'b0;
  logic        rst;
  logic [15:0] keys;
  logic        mode;
  logic [4:0]  eBCD;
  logic [3:0]  key_count;
  logic        key_pressed, overflow;

  int n_checks = 0;
  int n_fail   = 0;

  key_buffer #(.DEPTH(DEPTH), .DEB_CYCLES(DEB)) dut (
    .sw_clk      (sw_clk),
    .rst         (rst),
    .keys        (keys),
    .mode        (mode),
    .eBCD        (eBCD),
    .key_count   (key_count),
    .key_pressed (key_pressed),
    .overflow    (overflow)
  );

  always #5 sw_clk = ~sw_clk;

  // ---------------- reference model ----------------
  // Press: a single key must be seen DEB consecutive samples in a row
  // (a different pattern in the middle abandons the attempt).
  // Release: after acceptance, DEB consecutive all-zero samples re-arm.
  logic [15:0] m_samp, m_last;
  int          m_run, m_zrun;
  bit          m_held, m_kp, m_ov;
  logic [3:0]  q[$];

  always @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_samp = '0; m_last = '0; m_run = 0; m_zrun = 0;
      m_held = 0; m_kp = 0; m_ov = 0;
    end else begin : step
      bit do_push, do_pop;
      logic [3:0] code;
      do_push = 0;
      code    = '0;
      if (!m_held) begin
        if (m_run > 0) begin
          if (m_samp == m_last) begin
            m_run++;
            if (m_run == DEB) begin do_push = 1; m_held = 1; m_run = 0; end
          end else m_run = 0;
        end else if ($countones(m_samp) == 1) begin
          m_run  = 1;
          m_last = m_samp;
        end
      end else begin
        if (m_samp == 0) begin
          m_zrun++;
          if (m_zrun == DEB) begin m_held = 0; m_zrun = 0; end
        end else m_zrun = 0;
      end
      for (int i = 0; i < 16; i++) if (m_last[i]) code = 4'(i);
      do_pop = mode && (q.size() > 0);
      m_ov   = do_push && (q.size() == DEPTH) && !do_pop;
      if (do_pop) void'(q.pop_front());
      if (do_push && !m_ov) q.push_back(code);
      m_kp   = do_push;
      m_samp = keys;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cmp_all();
    logic [4:0] exp_e;
    exp_e = (q.size() > 0) ? {~mode, q[0]} : 5'h00;
    chk("eBCD", 32'(eBCD), 32'(exp_e));
    chk("key_count", 32'(key_count), 32'(q.size()));
    chk("key_pressed", 32'(key_pressed), 32'(m_kp));
    chk("overflow", 32'(overflow), 32'(m_ov));
  endtask

  // Compare at the falling edge, then return 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge sw_clk);
      cmp_all();
      @(posedge sw_clk);
      #1;
    end
  endtask

  task automatic press(input int c);
    keys = 16'h1 << c;
    tick(5);
    keys = '0;
    tick(6);
  endtask

  task automatic drain();
    repeat (DEPTH + 1) begin
      mode = 1'b1; tick(1);
      mode = 1'b0; tick(1);
    end
  endtask

  initial begin
    rst = 1'b0; keys = '0; mode = 1'b0;
    #1;
    chk("reset_eBCD", 32'(eBCD), 32'h0);
    chk("reset_count", 32'(key_count), 32'h0);
    tick(3);
    rst = 1'b1;
    tick(20);
    chk("idle_eBCD", 32'(eBCD), 32'h0);
    chk("idle_count", 32'(key_count), 32'h0);

    // Single press of key 3 held 4 samples.
    keys = 16'h0008; tick(4);
    keys = '0;       tick(1);
    chk("press3_pulse", 32'(key_pressed), 32'h1);
    chk("press3_eBCD", 32'(eBCD), 32'h13);
    tick(6);
    chk("press3_count", 32'(key_count), 32'h1);

    // Bounce before acceptance, then stable.
    for (int i = 0; i < 4; i++) begin keys = (i % 2 == 0) ? 16'h0008 : 16'h0; tick(1); end
    keys = 16'h0008; tick(6);
    keys = '0;       tick(6);
    // Bounce on release after a completed press.
    keys = 16'h0008; tick(6);
    keys = '0;       tick(2);
    keys = 16'h0008; tick(1);
    keys = '0;       tick(6);
    chk("bounce_count", 32'(key_count), 32'h3);

    // Chord is ignored.
    keys = 16'h0006; tick(10);
    keys = '0;       tick(6);
    chk("chord_count", 32'(key_count), 32'h3);

    // Consume 1,2,3 with one-cycle mode pulses.
    drain();
    press(1); press(2); press(3);
    chk("q123_eBCD", 32'(eBCD), 32'h11);
    chk("q123_count", 32'(key_count), 32'h3);
    begin
      logic [4:0] exp_seq [3];
      exp_seq[0] = 5'h12; exp_seq[1] = 5'h13; exp_seq[2] = 5'h00;
      for (int i = 0; i < 3; i++) begin
        mode = 1'b1; #1;
        chk("mode_masks_valid", 32'(eBCD[4]), 32'h0);
        tick(1);
        mode = 1'b0; #1;
        chk("consume_head", 32'(eBCD), 32'(exp_seq[i]));
        tick(1);
      end
    end
    chk("consume_count", 32'(key_count), 32'h0);

    // Fill, then overflow.
    for (int c = 0; c < DEPTH; c++) press(c);
    chk("fill_count", 32'(key_count), 32'h8);
    keys = 16'h8000; tick(4);
    keys = '0;       tick(1);
    chk("ovf_pulse", 32'(overflow), 32'h1);
    chk("ovf_kp", 32'(key_pressed), 32'h1);
    chk("ovf_count", 32'(key_count), 32'h8);
    chk("ovf_head", 32'(eBCD), 32'h10);
    tick(6);
    // Full with a pop on the push edge: accepted.
    keys = 16'h8000; tick(4);
    mode = 1'b1; keys = '0; tick(1);
    mode = 1'b0; #1;
    chk("fullpop_ovf", 32'(overflow), 32'h0);
    chk("fullpop_count", 32'(key_count), 32'h8);
    chk("fullpop_head", 32'(eBCD), 32'h11);
    tick(6);
    repeat (DEPTH - 1) begin mode = 1'b1; tick(1); mode = 1'b0; tick(1); end
    chk("last_is_F", 32'(eBCD), 32'h1F);
    drain();

    // Reset mid-fill with a key held through reset release.
    press(4); press(5);
    keys = 16'h0040; tick(2);
    rst = 1'b0; #1;
    chk("midrst_count", 32'(key_count), 32'h0);
    chk("midrst_eBCD", 32'(eBCD), 32'h0);
    tick(3);
    rst = 1'b1;
    tick(3);
    chk("held_thru_rst_wait", 32'(key_count), 32'h0);
    tick(7);
    chk("held_thru_rst_cnt", 32'(key_count), 32'h1);
    chk("held_thru_rst_eBCD", 32'(eBCD), 32'h16);
    keys = '0; tick(6);

    // Randomized stimulus against the model.
    for (int it = 0; it < 600; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4)       keys = '0;
      else if (r < 9)  keys = 16'h1 << $urandom_range(0, 15);
      else             keys = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      mode = ($urandom_range(0, 3) == 0);
      tick($urandom_range(1, 8));
    end
    mode = 1'b0; keys = '0;
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
